// File: rtl/overlay_fetch.sv
// Overlay picture fetcher: streams RGBA4444 pixels from SDRAM
// through a prefetch FIFO, one pixel per active ce_pix.
module overlay_fetch #(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FRAME_PIX  = 76800,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              Reset_I,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vsync,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_req,
  input  logic              sd_valid,
  input  logic [31:0]       sd_data,
  output logic [15:0]       pix_rgba,
  output logic              pix_valid,
  output logic              underflow
);

  localparam int unsigned WORDS = FRAME_PIX / 2;
  localparam int unsigned WC_W  = $clog2(WORDS + 1);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [WC_W-1:0]   WC_MAX = WC_W'(WORDS);
  localparam logic [CW-1:0]     DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_q;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              half_q;
  logic              drop_q;
  logic [WC_W-1:0]   wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       pix_q;
  logic              pv_q;
  logic              uf_q;

  logic        fs, act, blk, empty;
  logic        got, push, pop;
  logic [31:0] head;

  assign fs    = enable & vsync & ~vsync_q;
  assign act   = ce_pix & ~hblank & ~vblank;
  assign blk   = ce_pix & (hblank | vblank);
  assign empty = (count == '0);
  assign got   = (state_q == S_WAIT) & sd_valid;
  assign push  = enable & got & ~drop_q & ~fs;
  assign pop   = act & ~empty & half_q & ~fs;
  assign head  = mem[rd_ptr];

  assign sd_req    = (state_q == S_REQ) & enable;
  assign sd_addr   = addr_q;
  assign pix_rgba  = pix_q;
  assign pix_valid = pv_q;
  assign underflow = uf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (count < DEPTH && wcnt < WC_MAX)
          state_d = S_REQ;
      S_REQ:
        state_d = S_WAIT;
      S_WAIT:
        if (sd_valid)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (!enable)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge Reset_I) begin
    if (!Reset_I) vsync_q <= 1'b0;
    else          vsync_q <= vsync;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= sd_data;
  end

  always_ff @(posedge clk or negedge Reset_I) begin
    if (!Reset_I) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      half_q  <= 1'b0;
      drop_q  <= 1'b0;
      wcnt    <= '0;
      addr_q  <= BASE;
      pix_q   <= '0;
      pv_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else if (!enable) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      half_q  <= 1'b0;
      drop_q  <= 1'b0;
      wcnt    <= '0;
      addr_q  <= BASE;
      pix_q   <= '0;
      pv_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fs) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        half_q <= 1'b0;
        wcnt   <= '0;
        addr_q <= BASE;
        uf_q   <= 1'b0;
        // A read in flight now belongs to the old frame
        drop_q <= (state_q == S_REQ) |
                  ((state_q == S_WAIT) & ~sd_valid);
      end else begin
        if (got & drop_q)
          drop_q <= 1'b0;
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          addr_q <= addr_q + ADDR_W'(2);
          wcnt   <= wcnt + WC_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (act) begin
          if (empty) uf_q   <= 1'b1;
          else       half_q <= ~half_q;
        end
      end
      if (act) begin
        pv_q  <= ~empty;
        pix_q <= empty  ? 16'h0000 :
                 half_q ? head[31:16] : head[15:0];
      end else if (blk) begin
        pv_q  <= 1'b0;
        pix_q <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_overlay_fetch.sv
// Directed bench for overlay_fetch: two instances, one with
// the full frame size and one with an 8-pixel frame.
module tb_overlay_fetch;

  localparam logic [23:0] BA = 24'h000100;
  localparam logic [23:0] BB = 24'h000040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic        ce_pix, hblank, vblank, vsync;
  logic [23:0] addr_a, addr_b;
  logic        req_a, req_b;
  logic        val_a, val_b;
  logic [31:0] dat_a, dat_b;
  logic [15:0] rgba_a, rgba_b;
  logic        pv_a, pv_b;
  logic        uf_a, uf_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  overlay_fetch #(
    .BASE_ADDR(32'h100), .ADDR_W(24),
    .FRAME_PIX(76800), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .Reset_I(rst_n), .enable(en_a),
    .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .vsync(vsync), .sd_addr(addr_a), .sd_req(req_a),
    .sd_valid(val_a), .sd_data(dat_a),
    .pix_rgba(rgba_a), .pix_valid(pv_a), .underflow(uf_a)
  );

  overlay_fetch #(
    .BASE_ADDR(32'h40), .ADDR_W(24),
    .FRAME_PIX(8), .FIFO_DEPTH(8)
  ) dut_f (
    .clk(clk), .Reset_I(rst_n), .enable(en_b),
    .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .vsync(vsync), .sd_addr(addr_b), .sd_req(req_b),
    .sd_valid(val_b), .sd_data(dat_b),
    .pix_rgba(rgba_b), .pix_valid(pv_b), .underflow(uf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic h);
    ce_pix = 1'b1;
    hblank = h;
    tick();
    ce_pix = 1'b0;
    hblank = 1'b1;
  endtask

  task automatic restart(input bit b);
    vsync = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    tick();
    tick();
    if (b) en_b = 1'b1;
    else   en_a = 1'b1;
    vsync = 1'b1;
  endtask

  task automatic serve(input bit b, input logic [31:0] d,
                       input int budget,
                       output logic [23:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < budget; i++) begin
      if ((b ? req_b : req_a) === 1'b1) begin
        ok = 1'b1;
        a  = b ? addr_b : addr_a;
        break;
      end
      tick();
    end
    if (ok) begin
      tick();
      if (b) begin val_b = 1'b1; dat_b = d; end
      else   begin val_a = 1'b1; dat_a = d; end
      tick();
      val_a = 1'b0;
      val_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    repeat (10) tick();
    tests++;
    if (req_a !== 1'b0 || req_b !== 1'b0) begin
      fails++;
      $display("FAIL rst_req: got %b%b want 00", req_a, req_b);
    end
    tests++;
    if (addr_a !== BA || addr_b !== BB) begin
      fails++;
      $display("FAIL rst_addr: got %h/%h want %h/%h",
               addr_a, addr_b, BA, BB);
    end
    tests++;
    if (rgba_a !== 16'h0 || pv_a !== 1'b0 || uf_a !== 1'b0) begin
      fails++;
      $display("FAIL rst_out: got %h %b %b want 0000 0 0",
               rgba_a, pv_a, uf_a);
    end
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_a === 1'b1 || req_b === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL disabled_req: got %0d pulses want 0", seen);
    end
    tests++;
    if (rgba_a !== 16'h0 || pv_a !== 1'b0 || uf_a !== 1'b0) begin
      fails++;
      $display("FAIL disabled_out: got %h %b %b want 0000 0 0",
               rgba_a, pv_a, uf_a);
    end
  endtask

  task automatic test_fetch_order();
    logic [23:0] a;
    bit ok;
    restart(0);
    serve(0, 32'h22221111, 3, a, ok);
    tests++;
    if (!ok || a !== BA) begin
      fails++;
      $display("FAIL first_req: got ok=%0d addr %h want 1 %h",
               ok, a, BA);
    end
    serve(0, 32'h44443333, 4, a, ok);
    tests++;
    if (!ok || a !== BA + 24'd2) begin
      fails++;
      $display("FAIL second_req: got ok=%0d addr %h want 1 %h",
               ok, a, BA + 24'd2);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h1111 || pv_a !== 1'b1) begin
      fails++;
      $display("FAIL pix0: got %h %b want 1111 1", rgba_a, pv_a);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h2222 || pv_a !== 1'b1) begin
      fails++;
      $display("FAIL pix1: got %h %b want 2222 1", rgba_a, pv_a);
    end
    tick();
    tick();
    tests++;
    if (rgba_a !== 16'h2222 || pv_a !== 1'b1) begin
      fails++;
      $display("FAIL pix_hold: got %h %b want 2222 1", rgba_a, pv_a);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h3333 || pv_a !== 1'b1) begin
      fails++;
      $display("FAIL pix2: got %h %b want 3333 1", rgba_a, pv_a);
    end
  endtask

  task automatic test_fifo_full();
    logic [23:0] a, last;
    logic [31:0] d;
    bit ok;
    int n;
    restart(0);
    n    = 0;
    last = '0;
    for (int k = 0; k < 12; k++) begin
      d = {16'h1001 + 16'(2 * k), 16'h1000 + 16'(2 * k)};
      serve(0, d, 6, a, ok);
      if (!ok) break;
      n++;
      last = a;
    end
    tests++;
    if (n != 8 || last !== BA + 24'd14) begin
      fails++;
      $display("FAIL full_reqs: got %0d last %h want 8 %h",
               n, last, BA + 24'd14);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h1000) begin
      fails++;
      $display("FAIL full_pix0: got %h want 1000", rgba_a);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h1001) begin
      fails++;
      $display("FAIL full_pix1: got %h want 1001", rgba_a);
    end
    n    = 0;
    last = '0;
    for (int k = 0; k < 4; k++) begin
      serve(0, 32'h55554444, 6, a, ok);
      if (!ok) break;
      n++;
      last = a;
    end
    tests++;
    if (n != 1 || last !== BA + 24'd16) begin
      fails++;
      $display("FAIL refill: got %0d last %h want 1 %h",
               n, last, BA + 24'd16);
    end
    pix(1'b1);
    tests++;
    if (rgba_a !== 16'h0 || pv_a !== 1'b0) begin
      fails++;
      $display("FAIL blank_pix: got %h %b want 0000 0", rgba_a, pv_a);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h1002 || pv_a !== 1'b1) begin
      fails++;
      $display("FAIL after_blank: got %h %b want 1002 1",
               rgba_a, pv_a);
    end
  endtask

  task automatic test_underflow();
    restart(0);
    repeat (4) tick();
    tests++;
    if (uf_a !== 1'b0) begin
      fails++;
      $display("FAIL uf_pre: got %b want 0", uf_a);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h0 || pv_a !== 1'b0 || uf_a !== 1'b1) begin
      fails++;
      $display("FAIL uf_set: got %h %b %b want 0000 0 1",
               rgba_a, pv_a, uf_a);
    end
    repeat (3) tick();
    vsync = 1'b0;
    tick();
    tests++;
    if (uf_a !== 1'b1) begin
      fails++;
      $display("FAIL uf_sticky: got %b want 1", uf_a);
    end
    vsync = 1'b1;
    tick();
    tests++;
    if (uf_a !== 1'b0) begin
      fails++;
      $display("FAIL uf_clear: got %b want 0", uf_a);
    end
  endtask

  task automatic test_frame_end();
    logic [23:0] a;
    logic [23:0] seen [4];
    bit ok;
    int n;
    restart(1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      serve(1, 32'h0, 6, a, ok);
      if (!ok) break;
      if (n < 4) seen[n] = a;
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL frame_reqs: got %0d want 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k < n && seen[k] !== BB + 24'(2 * k)) begin
        fails++;
        $display("FAIL frame_addr%0d: got %h want %h",
                 k, seen[k], BB + 24'(2 * k));
      end
    end
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    serve(1, 32'h0, 4, a, ok);
    tests++;
    if (!ok || a !== BB) begin
      fails++;
      $display("FAIL frame_restart: got ok=%0d addr %h want 1 %h",
               ok, a, BB);
    end
    en_b = 1'b0;
  endtask

  task automatic test_stale();
    logic [23:0] a;
    bit ok;
    bit hit;
    restart(0);
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req_a === 1'b1) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL stale_req: got none want pulse");
    end
    tick();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    val_a = 1'b1;
    dat_a = 32'hDEADBEEF;
    tick();
    val_a = 1'b0;
    serve(0, 32'h00020001, 4, a, ok);
    tests++;
    if (!ok || a !== BA) begin
      fails++;
      $display("FAIL stale_addr: got ok=%0d addr %h want 1 %h",
               ok, a, BA);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h0001 || pv_a !== 1'b1) begin
      fails++;
      $display("FAIL stale_pix0: got %h %b want 0001 1",
               rgba_a, pv_a);
    end
    pix(1'b0);
    tests++;
    if (rgba_a !== 16'h0002) begin
      fails++;
      $display("FAIL stale_pix1: got %h want 0002", rgba_a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    ce_pix = 1'b0;
    hblank = 1'b1;
    vblank = 1'b0;
    vsync  = 1'b0;
    val_a  = 1'b0;
    val_b  = 1'b0;
    dat_a  = '0;
    dat_b  = '0;
    test_reset();
    test_fetch_order();
    test_fifo_full();
    test_underflow();
    test_frame_end();
    test_stale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/overlay_fetch.md
Name: overlay_fetch

Overview:
- Streams the RGBA4444 overlay picture out of SDRAM for the monochrome Subs video path, in raster order, one pixel per `ce_pix` during active video.
- Sits between the SDRAM read channel (ch1) and the alpha-blend/overlay-mix stage. It replaces ad-hoc fetch logic with a prefetch FIFO and an explicit request/valid handshake.
- Restarts at the overlay base address on every rising edge of `vsync`.

Parameters:
- `BASE_ADDR`, 0: SDRAM 16-bit word address of the first overlay pixel.
- `ADDR_W`, 24: width of the SDRAM word address.
- `FRAME_PIX`, 76800: pixels per frame (320x240). Must be even.
- `FIFO_DEPTH`, 8: 32-bit entries in the prefetch FIFO. Must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: video/memory clock (48 MHz domain).
- `Reset_I`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: overlay loaded and not downloading. 0 forces idle.
- `ce_pix`, in, 1: pixel clock enable.
- `hblank`, in, 1: horizontal blank.
- `vblank`, in, 1: vertical blank.
- `vsync`, in, 1: vertical sync, active high. Rising edge = frame start.
- `sd_addr`, out, `ADDR_W`: word address of the current read; always even.
- `sd_req`, out, 1: one-cycle read request pulse.
- `sd_valid`, in, 1: one-cycle strobe, `sd_data` valid.
- `sd_data`, in, 32: {pixel n+1, pixel n}; low half is the earlier pixel.
- `pix_rgba`, out, 16: {a,b,g,r}, 4 bits each.
- `pix_valid`, out, 1: `pix_rgba` holds real overlay data.
- `underflow`, out, 1: sticky; FIFO was empty when a pixel was due.

Behaviour:
- **Reset (`Reset_I`=0, async):**
  - FIFO emptied; read/write pointers, count, half-select, outstanding flag, drop flag and word counter cleared.
  - `sd_addr`=`BASE_ADDR`, `sd_req`=0, `pix_rgba`=0, `pix_valid`=0, `underflow`=0.
  - Reset asserted mid-operation aborts everything. A later `sd_valid` with no request outstanding is ignored.
- **Disable (`enable`=0):** same clearing as reset, but synchronous. No requests issued; outputs 0.
- **Frame start:** `vsync` is registered. A rising edge (`vsync` & ~`vsync_q`) while enabled, sampled regardless of `ce_pix`, does the following in one cycle:
  - flush FIFO and half-select;
  - `sd_addr`=`BASE_ADDR`, word counter=0;
  - clear `underflow`;
  - if a request is outstanding, set the drop flag.
- **Fetch FSM (IDLE, REQ, WAIT):**
  - IDLE→REQ when enabled, no outstanding request, count < `FIFO_DEPTH`, and word counter < `FRAME_PIX`/2.
  - REQ: `sd_req`=1 for exactly one cycle with `sd_addr` stable; then go to WAIT.
  - WAIT: on `sd_valid`:
    - if the drop flag is set, discard the data and clear the flag;
    - otherwise push `sd_data`, `sd_addr` += 2, word counter += 1.
    - Return to IDLE either way.
  - At most one request is outstanding; `sd_addr` changes only in WAIT→IDLE or at frame start.
  - When the word counter reaches `FRAME_PIX`/2, no further requests are made until the next frame start.
- **Pixel side:** acts when `ce_pix` & ~`hblank` & ~`vblank`, registered with 1-cycle latency.
  - FIFO non-empty:
    - `pix_rgba` = half-select ? head[31:16] : head[15:0], `pix_valid`=1;
    - toggle half-select;
    - pop the head when the high half is emitted.
  - FIFO empty: `pix_rgba`=0, `pix_valid`=0, `underflow`←1, half-select unchanged.
- **Blanking:** `ce_pix` during blank sets `pix_rgba`=0 and `pix_valid`=0. Outputs hold between `ce_pix` strobes.
- **Simultaneous push and pop in one cycle:** count unchanged, no data loss. A push with count=`FIFO_DEPTH` cannot occur by construction; the verifier asserts it never happens.
- **Frame start coinciding with push or pop:** the flush takes priority. A coinciding valid push is treated as dropped.
- **Widths:** `sd_addr` wraps modulo 2^`ADDR_W`. The word counter is ceil(log2(`FRAME_PIX`/2 + 1)) bits.

Test Plan:
1. Reset held 10 cycles, then release with `enable`=0 → `sd_req` never 1, `pix_rgba`=0x0000, `pix_valid`=0, `underflow`=0.
2. Fetch order: `enable`=1, `vsync` rise → `sd_req` pulse with `sd_addr`=`BASE_ADDR` within 2 cycles. Answer with 0x22221111. First two active pixels → 0x1111 then 0x2222, `pix_valid`=1. Next request at `BASE_ADDR`+2.
3. FIFO full: answer every request, keep `hblank`=1 → exactly 8 requests (`FIFO_DEPTH`=8), then `sd_req` stays 0. After 2 active pixels → exactly one new request.
4. Underflow: never assert `sd_valid`, drive an active pixel → `pix_rgba`=0, `pix_valid`=0, `underflow`=1. It stays 1 until the next `vsync` rise, then clears.
5. Frame end with `FRAME_PIX`=8: answer all requests → exactly 4 requests (addresses `BASE_ADDR`, +2, +4, +6). No more until `vsync` rise, which restarts at `BASE_ADDR`.
6. Stale data: request outstanding, `vsync` rise, then `sd_valid` with 0xDEADBEEF → discarded. New request at `BASE_ADDR` answered 0x00020001 → first pixel 0x0001.
